// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared constants for the push-button conditioner: display view encodings,
// button role indices and the default debounce window.
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

  // 10 ms stability window at a 100 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Display source selected by view_sel; the encoding 3 is never produced.
  typedef enum logic [1:0] {
    VIEW_INSTR  = 2'd0,
    VIEW_ALUOUT = 2'd1,
    VIEW_RD2    = 2'd2
  } view_e;

  localparam int VIEW_COUNT = 3;

  // Role of each of the first three button channels.
  localparam int BTN_VIEW  = 0;
  localparam int BTN_HALF  = 1;
  localparam int BTN_CLEAR = 2;

  // Advance through the views in order, wrapping from the last back to
  // VIEW_INSTR.
  function automatic view_e next_view(input view_e v);
    if (int'(v) + 1 >= VIEW_COUNT) return VIEW_INSTR;
    return view_e'(v + 2'd1);
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One push-button channel: two-flop synchronizer, stability counter,
// debounced level and registered one-cycle press/release pulses.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   i_raw      asynchronous, bouncing button level (1 = pressed)
//   o_level    debounced level
//   o_press    one-cycle pulse when o_level newly becomes 1
//   o_release  one-cycle pulse when o_level newly becomes 0
// ---------------------------------------------------------------------------
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  logic w_mismatch;
  logic w_commit;

  // Only the second synchronizer stage feeds the debounce logic.
  assign w_mismatch = r_sync2 ^ r_level;
  // The counter has already seen DEBOUNCE_CYCLES-1 mismatching edges, so this
  // edge is the DEBOUNCE_CYCLES-th: accept the new level.
  assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // blocking assignments would collapse the synchronizer into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;

      // Clearing on commit keeps the counter from ever passing CNT_LAST.
      if (!w_mismatch || w_commit) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;

      if (w_commit) r_level <= r_sync2;

      // Pulses are registered alongside the level so they line up with the
      // cycle in which the new level first appears.
      r_press   <= w_commit &  r_sync2;
      r_release <= w_commit & ~r_sync2;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Debounces N_BTNS push buttons and uses the first three to drive the display
// selection: button 0 cycles the view, button 1 toggles the half, button 2
// clears both. Higher channels are conditioned but have no selection role.
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset
//   btn_raw      raw asynchronous button levels (1 = pressed)
//   btn_level    debounced level per button
//   btn_press    one-cycle pulse per debounced 0->1 transition
//   btn_release  one-cycle pulse per debounced 1->0 transition
//   view_sel     display source: 0=instr, 1=aluout, 2=rd2
//   half_sel     display half: 0 = bits 15:0, 1 = bits 31:16
// ---------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTNS          = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTNS-1:0] btn_raw,
  output logic [N_BTNS-1:0] btn_level,
  output logic [N_BTNS-1:0] btn_press,
  output logic [N_BTNS-1:0] btn_release,
  output logic [1:0]        view_sel,
  output logic              half_sel
);

  for (genvar g = 0; g < N_BTNS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

  view_e r_view;
  logic  r_half;
  view_e w_view_next;
  logic  w_half_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_view <= VIEW_INSTR;
      r_half <= 1'b0;
    end else begin
      r_view <= w_view_next;
      r_half <= w_half_next;
    end
  end

  // NOTE: both outputs get a hold default first, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    w_view_next = r_view;
    w_half_next = r_half;
    if (btn_press[BTN_CLEAR]) begin
      // Clear wins over any simultaneous view/half press.
      w_view_next = VIEW_INSTR;
      w_half_next = 1'b0;
    end else begin
      if (btn_press[BTN_VIEW]) w_view_next = next_view(r_view);
      if (btn_press[BTN_HALF]) w_half_next = ~r_half;
    end
  end

  always_comb begin
    view_sel = r_view;
    half_sel = r_half;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4 and four
// channels. Expected pulses are queued with the cycle they must appear in;
// a negedge monitor matches every observed pulse against that queue.
// A change driven at a negedge with cycle count c is first sampled on edge
// c+1 and must reach btn_level on the sixth edge counted from there, c+6.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int LAT = 2 + D;

  typedef struct {
    int cyc;
    int ch;
    bit rise;
  } ev_t;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [1:0]   view_sel;
  logic         half_sel;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  int  exp_view = 0;
  bit  exp_half = 1'b0;
  ev_t sb[$];

  button_conditioner #(
    .N_BTNS          (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .view_sel    (view_sel),
    .half_sel    (half_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse seen must match a queued expectation for this exact cycle.
  always @(negedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      for (int k = 0; k < 2; k++) begin
        logic seen;
        int   idx;
        seen = (k == 0) ? btn_press[ch] : btn_release[ch];
        if (seen !== 1'b0) begin
          idx = -1;
          foreach (sb[j])
            if (idx < 0 && sb[j].cyc == cyc && sb[j].ch == ch && sb[j].rise == (k == 0))
              idx = j;
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL pulse_sb: %s ch%0d at cycle %0d got %b, expected no pulse",
                     (k == 0) ? "press" : "release", ch, cyc, seen);
          end else begin
            sb.delete(idx);
          end
        end
      end
    end
  end

  function automatic int overdue();
    int n = 0;
    foreach (sb[j]) if (sb[j].cyc < cyc) n++;
    return n;
  endfunction

  task automatic push_events(input logic [N-1:0] mask, input bit rise);
    for (int ch = 0; ch < N; ch++) begin
      if (mask[ch]) begin
        ev_t e;
        e.cyc  = cyc + LAT;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
      end
    end
  endtask

  // Called at a negedge: press the buttons in mask, check latency, then the
  // selection state one edge after the press pulse.
  task automatic press_btns(input logic [N-1:0] mask);
    push_events(mask, 1'b1);
    btn_raw = btn_raw | mask;
    repeat (LAT - 1) @(negedge clk);
    total++;
    if ((btn_level & mask) !== '0) begin
      bad++;
      $display("FAIL press_early mask=%b: level=%b, required 0 on those bits", mask, btn_level);
    end
    @(negedge clk);
    total++;
    if ((btn_level & mask) !== mask) begin
      bad++;
      $display("FAIL press_latency mask=%b: level=%b, required those bits set", mask, btn_level);
    end
    @(negedge clk);
    if (mask[2]) begin
      exp_view = 0;
      exp_half = 1'b0;
    end else begin
      if (mask[0]) exp_view = (exp_view + 1) % 3;
      if (mask[1]) exp_half = !exp_half;
    end
    total++;
    if (view_sel !== 2'(exp_view)) begin
      bad++;
      $display("FAIL press_view mask=%b: view_sel=%0d, required %0d", mask, view_sel, exp_view);
    end
    total++;
    if (half_sel !== exp_half) begin
      bad++;
      $display("FAIL press_half mask=%b: half_sel=%b, required %b", mask, half_sel, exp_half);
    end
    total++;
    if (overdue() !== 0) begin
      bad++;
      $display("FAIL press_missing mask=%b: %0d expected pulses not seen, required 0", mask, overdue());
    end
  endtask

  task automatic release_btns(input logic [N-1:0] mask);
    push_events(mask, 1'b0);
    btn_raw = btn_raw & ~mask;
    repeat (LAT - 1) @(negedge clk);
    total++;
    if ((btn_level & mask) !== mask) begin
      bad++;
      $display("FAIL release_early mask=%b: level=%b, required those bits still set", mask, btn_level);
    end
    @(negedge clk);
    total++;
    if ((btn_level & mask) !== '0) begin
      bad++;
      $display("FAIL release_latency mask=%b: level=%b, required 0 on those bits", mask, btn_level);
    end
    @(negedge clk);
    total++;
    if (view_sel !== 2'(exp_view) || half_sel !== exp_half) begin
      bad++;
      $display("FAIL release_sel mask=%b: view=%0d half=%b, required view=%0d half=%b",
               mask, view_sel, half_sel, exp_view, exp_half);
    end
    total++;
    if (overdue() !== 0) begin
      bad++;
      $display("FAIL release_missing mask=%b: %0d expected pulses not seen, required 0", mask, overdue());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (btn_level !== '0) begin bad++; $display("FAIL reset_level: %b, required 0", btn_level); end
    total++;
    if (btn_press !== '0) begin bad++; $display("FAIL reset_press: %b, required 0", btn_press); end
    total++;
    if (btn_release !== '0) begin bad++; $display("FAIL reset_release: %b, required 0", btn_release); end
    total++;
    if (view_sel !== 2'd0) begin bad++; $display("FAIL reset_view: %0d, required 0", view_sel); end
    total++;
    if (half_sel !== 1'b0) begin bad++; $display("FAIL reset_half: %b, required 0", half_sel); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ((btn_press | btn_release) !== '0) begin
      bad++;
      $display("FAIL post_reset_pulse: press=%b release=%b, required 0", btn_press, btn_release);
    end
  endtask

  // Channel 3 has no selection role, so this also shows it leaves view/half alone.
  task automatic test_clean_press();
    push_events(4'b1000, 1'b1);
    btn_raw[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if (btn_level[3] !== (i >= LAT)) begin
        bad++;
        $display("FAIL hold_level edge %0d: level=%b, required %b", i, btn_level[3], (i >= LAT));
      end
    end
    total++;
    if (view_sel !== 2'(exp_view) || half_sel !== exp_half) begin
      bad++;
      $display("FAIL ch3_sel: view=%0d half=%b, required view=%0d half=%b",
               view_sel, half_sel, exp_view, exp_half);
    end
    release_btns(4'b1000);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_raw[0] = ((i / 2) % 2 == 0);
      @(negedge clk);
      total++;
      if (btn_level[0] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_level step %0d: level=%b, required 0", i, btn_level[0]);
      end
    end
    btn_raw[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      total++;
      if (btn_level[0] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_settle: level=%b, required 0", btn_level[0]);
      end
    end
    total++;
    if (view_sel !== 2'(exp_view)) begin
      bad++;
      $display("FAIL bounce_view: view=%0d, required %0d", view_sel, exp_view);
    end
  endtask

  // Expected view sequence 0 -> 1 -> 2 -> 0 -> 1.
  task automatic test_view_cycle();
    for (int i = 0; i < 4; i++) begin
      press_btns(4'b0001);
      release_btns(4'b0001);
    end
  endtask

  task automatic test_simultaneous();
    total++;
    if (view_sel !== 2'd1 || half_sel !== 1'b0) begin
      bad++;
      $display("FAIL simul_start: view=%0d half=%b, required view=1 half=0", view_sel, half_sel);
    end
    press_btns(4'b0011);
    release_btns(4'b0011);
    press_btns(4'b0111);
    release_btns(4'b0111);
  endtask

  task automatic test_reset_mid_press();
    btn_raw[0] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (btn_level[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_level: %b, required 0", btn_level[0]);
    end
    reset    = 1'b0;
    exp_view = 0;
    exp_half = 1'b0;
    push_events(4'b0001, 1'b1);
    @(negedge clk);
    total++;
    if ((btn_press | btn_release) !== '0) begin
      bad++;
      $display("FAIL midreset_first_cycle: press=%b release=%b, required 0", btn_press, btn_release);
    end
    repeat (LAT - 2) @(negedge clk);
    total++;
    if (btn_level[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_early: level=%b, required 0", btn_level[0]);
    end
    @(negedge clk);
    total++;
    if (btn_level[0] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_latency: level=%b, required 1", btn_level[0]);
    end
    @(negedge clk);
    exp_view = 1;
    total++;
    if (view_sel !== 2'(exp_view)) begin
      bad++;
      $display("FAIL midreset_view: view=%0d, required %0d", view_sel, exp_view);
    end
    release_btns(4'b0001);
  endtask

  task automatic test_release_btn1();
    press_btns(4'b0010);
    release_btns(4'b0010);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_view_cycle();
    test_simultaneous();
    test_reset_mid_press();
    test_release_btn1();
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drained: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
